quad_decoder: RTL and testbench

Quadrature rotary-encoder front end for the encoder peripheral. Synchronises the raw A/B pins, debounces them at the rate set by the periodic sample strobe that `strobe_gen` produces, decodes the Gray-code sequence, and maintains a signed-agnostic wrap-around position count with direction, step and error status for the peripheral register interface.

---
 rtl/quad_decoder.sv | 112 +++++++++++
 tb/tb_quad_decoder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// Quadrature encoder front end: pin synchronisers, strobe-paced debounce, Gray decode, wrapping count.
// Build option: define ENCODER_X4_EN to count every legal transition (x4); otherwise only steps into 00 count (x1).
module quad_decoder #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             strobe,
   input  logic             enc_a,
   input  logic             enc_b,
   input  logic             clr,
   output logic [WIDTH-1:0] count,
   output logic             dir,
   output logic             step,
   output logic             err
);

   // The incoming sample is the newest window entry, so only DEPTH-1 older samples are stored.
   localparam int HW = 2 * (DEPTH - 1);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic             a_meta_q, a_meta_d, a_s_q, a_s_d;
   logic             b_meta_q, b_meta_d, b_s_q, b_s_d;
   logic [HW-1:0]    hist_q, hist_d;
   logic [1:0]       deb_q, deb_d;
   logic             primed_q, primed_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             dir_q, dir_d;
   logic             step_q, step_d;
   logic             err_q, err_d;

   logic [1:0] sample;
   logic       match, accept, fwd, rev, illegal, count_en, counted;

   always_comb begin
      a_meta_d = enc_a;
      a_s_d    = a_meta_q;
      b_meta_d = enc_b;
      b_s_d    = b_meta_q;
      sample   = {a_s_q, b_s_q};

      match = 1'b1;
      for (int i = 0; i < DEPTH - 1; i++) begin
         if (hist_q[2*i +: 2] != sample) match = 1'b0;
      end
      accept = strobe && match && (sample != deb_q);
      hist_d = strobe ? HW'({hist_q, sample}) : hist_q;

      fwd = 1'b0;
      rev = 1'b0;
      case ({deb_q, sample})
         4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd = 1'b1;
         4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: rev = 1'b1;
         default: ;
      endcase
      illegal = ((deb_q ^ sample) == 2'b11);
`ifdef ENCODER_X4_EN
      count_en = 1'b1;
`else
      count_en = (sample == 2'b00);
`endif
      // The first acceptance after reset only loads deb.
      counted = accept && primed_q && (fwd || rev) && count_en;

      deb_d    = accept ? sample : deb_q;
      primed_d = primed_q | accept;
      dir_d    = counted ? fwd : dir_q;
      step_d   = counted && !clr;
      err_d    = err_q | (accept && primed_q && illegal);
      count_d  = count_q;
      if (counted) count_d = fwd ? count_q + ONE : count_q - ONE;
      if (clr) begin
         count_d = '0;
         err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_meta_q <= 1'b0;
         a_s_q    <= 1'b0;
         b_meta_q <= 1'b0;
         b_s_q    <= 1'b0;
         hist_q   <= '0;
         deb_q    <= 2'b00;
         primed_q <= 1'b0;
         count_q  <= '0;
         dir_q    <= 1'b0;
         step_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         a_meta_q <= a_meta_d;
         a_s_q    <= a_s_d;
         b_meta_q <= b_meta_d;
         b_s_q    <= b_s_d;
         hist_q   <= hist_d;
         deb_q    <= deb_d;
         primed_q <= primed_d;
         count_q  <= count_d;
         dir_q    <= dir_d;
         step_q   <= step_d;
         err_q    <= err_d;
      end
   end

   assign count = count_q;
   assign dir   = dir_q;
   assign step  = step_q;
   assign err   = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: Gray-position reference model plus directed and randomized scenarios.
// Follows the DUT build: define ENCODER_X4_EN for x4 expectations, x1 otherwise.
module tb_quad_decoder;
   localparam int WIDTH = 8;
   localparam int DEPTH = 3;
`ifdef ENCODER_X4_EN
   localparam bit X4 = 1'b1;
`else
   localparam bit X4 = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             strobe = 1'b0;
   logic             enc_a = 1'b0;
   logic             enc_b = 1'b0;
   logic             clr = 1'b0;
   logic [WIDTH-1:0] count;
   logic             dir, step, err;

   quad_decoder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .strobe(strobe), .enc_a(enc_a), .enc_b(enc_b),
      .clr(clr), .count(count), .dir(dir), .step(step), .err(err)
   );

   always #5 clk = ~clk;

   int    checks = 0;
   int    passes = 0;
   int    steps_seen;
   int    trace_bad;
   string first_bad;

   // Reference model: position on the Gray cycle, a pin-delay pipe and a window of strobe samples.
   logic [1:0]       m_pipe0, m_pipe1, m_deb;
   logic [1:0]       m_hist[$];
   bit               m_primed;
   logic [WIDTH-1:0] exp_count;
   logic             exp_dir, exp_step, exp_err;

   function automatic int pos(input logic [1:0] v);
      case (v)
         2'b00: return 0;
         2'b10: return 1;
         2'b11: return 2;
         default: return 3;
      endcase
   endfunction

   always @(posedge clk) begin
      logic [1:0] smp;
      bit         acc;
      int         d;
      if (!rst_n) begin
         m_pipe0 = 2'b00;
         m_pipe1 = 2'b00;
         m_deb = 2'b00;
         m_primed = 1'b0;
         m_hist.delete();
         for (int i = 0; i < DEPTH - 1; i++) m_hist.push_back(2'b00);
         exp_count = '0;
         exp_dir = 1'b0;
         exp_step = 1'b0;
         exp_err = 1'b0;
      end else begin
         smp = m_pipe0;
         m_pipe0 = m_pipe1;
         m_pipe1 = {enc_a, enc_b};
         exp_step = 1'b0;
         acc = 1'b0;
         if (strobe) begin
            acc = (smp != m_deb);
            foreach (m_hist[i]) if (m_hist[i] != smp) acc = 1'b0;
            m_hist.push_back(smp);
            void'(m_hist.pop_front());
         end
         if (acc) begin
            d = (pos(smp) - pos(m_deb) + 4) % 4;
            if (!m_primed) m_primed = 1'b1;
            else if (d == 2) exp_err = 1'b1;
            else if (X4 || smp == 2'b00) begin
               exp_dir = (d == 1);
               if (!clr) begin
                  exp_count = (d == 1) ? exp_count + WIDTH'(1) : exp_count - WIDTH'(1);
                  exp_step = 1'b1;
               end
            end
            m_deb = smp;
         end
         if (clr) begin
            exp_count = '0;
            exp_err = 1'b0;
         end
      end
   end

   // Driver: one clock with the given pins/controls, then records deviations from the model.
   task automatic drive_cycle(input logic [1:0] ab, input logic stb, input logic cl, input logic rst);
      {enc_a, enc_b} = ab;
      strobe = stb;
      clr = cl;
      rst_n = ~rst;
      @(posedge clk);
      @(negedge clk);
      if (step === 1'b1) steps_seen++;
      if ({count, dir, step, err} !== {exp_count, exp_dir, exp_step, exp_err}) begin
         if (trace_bad == 0)
            first_bad = $sformatf("t=%0t count/dir/step/err=%0h/%b/%b/%b model %0h/%b/%b/%b",
                                  $time, count, dir, step, err, exp_count, exp_dir, exp_step, exp_err);
         trace_bad++;
      end
   endtask

   // Hold pins for nper strobe periods of per cycles; clr rides on the strobe of period clr_at.
   task automatic hold(input logic [1:0] ab, input int nper, input int per, input int clr_at,
                       input logic stb_en);
      for (int p = 1; p <= nper; p++)
         for (int c = 0; c < per; c++)
            drive_cycle(ab, stb_en && (c == per - 1), (c == per - 1) && (p == clr_at), 1'b0);
   endtask

   task automatic start_trace();
      steps_seen = 0;
      trace_bad = 0;
      first_bad = "";
   endtask

   // Reset with pins at 10, accept 10 (prime), step to 00, then clear: primed at 00, count 0.
   task automatic prime_00();
      for (int i = 0; i < 3; i++) drive_cycle(2'b10, 1'b0, 1'b0, 1'b1);
      hold(2'b10, DEPTH, 4, 0, 1'b1);
      hold(2'b00, DEPTH, 4, 0, 1'b1);
      hold(2'b00, 1, 1, 1, 1'b1);
   endtask

   task automatic test_reset();
      start_trace();
      for (int i = 0; i < 4; i++) drive_cycle(2'b11, 1'b1, 1'b0, 1'b1);
      checks++;
      if ({count, dir, step, err} !== '0)
         $display("FAIL reset_vals: got %0h/%b/%b/%b, expected 0/0/0/0", count, dir, step, err);
      else passes++;
      hold(2'b11, DEPTH, 4, 0, 1'b1);
      checks++;
      if (steps_seen !== 0) $display("FAIL prime_step: got %0d pulses, expected 0", steps_seen);
      else passes++;
      checks++;
      if ({count, err} !== '0) $display("FAIL prime_state: got count=%0h err=%b, expected 0/0", count, err);
      else passes++;
      // From deb 11, 01 is a forward step (counted only in x4).
      hold(2'b01, DEPTH, 4, 0, 1'b1);
      checks++;
      if (count !== WIDTH'(X4 ? 1 : 0)) $display("FAIL prime_deb: got count=%0h, expected %0h", count, X4 ? 1 : 0);
      else passes++;
      checks++;
      if (trace_bad !== 0) $display("FAIL reset_trace: %0d cycles off, first %s", trace_bad, first_bad);
      else passes++;
   endtask

   task automatic test_forward();
      prime_00();
      start_trace();
      hold(2'b10, 5, 4, 0, 1'b1);
      hold(2'b11, 5, 4, 0, 1'b1);
      hold(2'b01, 5, 4, 0, 1'b1);
      hold(2'b00, 5, 4, 0, 1'b1);
      checks++;
      if (count !== WIDTH'(X4 ? 4 : 1)) $display("FAIL fwd_count: got %0h, expected %0h", count, X4 ? 4 : 1);
      else passes++;
      checks++;
      if (steps_seen !== (X4 ? 4 : 1)) $display("FAIL fwd_steps: got %0d, expected %0d", steps_seen, X4 ? 4 : 1);
      else passes++;
      checks++;
      if (dir !== 1'b1) $display("FAIL fwd_dir: got %b, expected 1", dir);
      else passes++;
      checks++;
      if (trace_bad !== 0) $display("FAIL fwd_trace: %0d cycles off, first %s", trace_bad, first_bad);
      else passes++;
   endtask

   task automatic test_reverse_wrap();
      prime_00();
      start_trace();
      // x4: 00->01 is reverse; x1: 00->10->00 is the reverse step.
      if (X4) hold(2'b01, 5, 4, 0, 1'b1);
      else begin
         hold(2'b10, 5, 4, 0, 1'b1);
         hold(2'b00, 5, 4, 0, 1'b1);
      end
      checks++;
      if ({count, dir} !== {{WIDTH{1'b1}}, 1'b0})
         $display("FAIL wrap_down: got count=%0h dir=%b, expected %0h/0", count, dir, {WIDTH{1'b1}});
      else passes++;
      if (X4) hold(2'b00, 5, 4, 0, 1'b1);
      else begin
         hold(2'b01, 5, 4, 0, 1'b1);
         hold(2'b00, 5, 4, 0, 1'b1);
      end
      checks++;
      if ({count, dir} !== {{WIDTH{1'b0}}, 1'b1})
         $display("FAIL wrap_up: got count=%0h dir=%b, expected 0/1", count, dir);
      else passes++;
      checks++;
      if (trace_bad !== 0) $display("FAIL wrap_trace: %0d cycles off, first %s", trace_bad, first_bad);
      else passes++;
   endtask

   task automatic test_glitch();
      prime_00();
      start_trace();
      hold(2'b10, DEPTH - 1, 4, 0, 1'b1);
      hold(2'b00, 4, 4, 0, 1'b1);
      checks++;
      if ({count, err} !== '0 || steps_seen !== 0)
         $display("FAIL glitch_reject: got count=%0h err=%b steps=%0d, expected 0/0/0", count, err, steps_seen);
      else passes++;
      hold(2'b10, DEPTH, 4, 0, 1'b1);
      checks++;
      if (count !== WIDTH'(X4 ? 1 : 0)) $display("FAIL glitch_accept: got %0h, expected %0h", count, X4 ? 1 : 0);
      else passes++;
      checks++;
      if (trace_bad !== 0) $display("FAIL glitch_trace: %0d cycles off, first %s", trace_bad, first_bad);
      else passes++;
   endtask

   task automatic test_illegal_clr();
      prime_00();
      start_trace();
      hold(2'b11, DEPTH, 4, 0, 1'b1);
      checks++;
      if ({count, err} !== {{WIDTH{1'b0}}, 1'b1} || steps_seen !== 0)
         $display("FAIL illegal: got count=%0h err=%b steps=%0d, expected 0/1/0", count, err, steps_seen);
      else passes++;
      hold(2'b01, DEPTH, 4, 0, 1'b1);
      checks++;
      if (err !== 1'b1) $display("FAIL err_sticky: got %b, expected 1", err);
      else passes++;
      steps_seen = 0;
      // clr lands exactly on the strobe that accepts the forward 01->00 step.
      hold(2'b00, DEPTH, 4, DEPTH, 1'b1);
      drive_cycle(2'b00, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({count, err, dir} !== {{WIDTH{1'b0}}, 1'b0, 1'b1} || steps_seen !== 0)
         $display("FAIL clr_step: got count=%0h err=%b dir=%b steps=%0d, expected 0/0/1/0",
                  count, err, dir, steps_seen);
      else passes++;
      checks++;
      if (trace_bad !== 0) $display("FAIL illegal_trace: %0d cycles off, first %s", trace_bad, first_bad);
      else passes++;
   endtask

   task automatic test_mid_reset();
      prime_00();
      start_trace();
      hold(2'b10, DEPTH - 1, 4, 0, 1'b1);
      drive_cycle(2'b10, 1'b0, 1'b0, 1'b1);
      hold(2'b10, DEPTH + 1, 4, 0, 1'b1);
      checks++;
      if (count !== '0 || steps_seen !== 0)
         $display("FAIL midrst_prime: got count=%0h steps=%0d, expected 0/0", count, steps_seen);
      else passes++;
      hold(2'b00, DEPTH, 4, 0, 1'b1);
      checks++;
      if ({count, dir} !== {{WIDTH{1'b1}}, 1'b0} || steps_seen !== 1)
         $display("FAIL midrst_step: got count=%0h dir=%b steps=%0d, expected %0h/0/1",
                  count, dir, steps_seen, {WIDTH{1'b1}});
      else passes++;
      checks++;
      if (trace_bad !== 0) $display("FAIL midrst_trace: %0d cycles off, first %s", trace_bad, first_bad);
      else passes++;
   endtask

   task automatic test_strobe_modes();
      prime_00();
      start_trace();
      hold(2'b10, 40, 1, 0, 1'b0);
      hold(2'b11, 40, 1, 0, 1'b0);
      checks++;
      if (count !== '0 || steps_seen !== 0 || err !== 1'b0)
         $display("FAIL no_strobe: got count=%0h steps=%0d err=%b, expected 0/0/0", count, steps_seen, err);
      else passes++;
      prime_00();
      hold(2'b10, DEPTH + 3, 1, 0, 1'b1);
      hold(2'b11, DEPTH + 3, 1, 0, 1'b1);
      hold(2'b01, DEPTH + 3, 1, 0, 1'b1);
      hold(2'b00, DEPTH + 3, 1, 0, 1'b1);
      checks++;
      if (count !== WIDTH'(X4 ? 4 : 1)) $display("FAIL cont_strobe: got %0h, expected %0h", count, X4 ? 4 : 1);
      else passes++;
      checks++;
      if (trace_bad !== 0) $display("FAIL strobe_trace: %0d cycles off, first %s", trace_bad, first_bad);
      else passes++;
   endtask

   task automatic test_random();
      logic [1:0] gray[4];
      int idx, r, cl;
      gray = '{2'b00, 2'b10, 2'b11, 2'b01};
      prime_00();
      start_trace();
      idx = 0;
      for (int n = 0; n < 250; n++) begin
         r = int'($urandom_range(0, 9));
         if (r < 4) idx = (idx + 1) % 4;
         else if (r < 8) idx = (idx + 3) % 4;
         else if (r == 8) idx = (idx + 2) % 4;
         if ($urandom_range(0, 40) == 0) drive_cycle(gray[idx], 1'b1, 1'b0, 1'b1);
         cl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
         hold(gray[idx], int'($urandom_range(1, 5)), int'($urandom_range(1, 4)), cl,
              $urandom_range(0, 15) != 0);
      end
      checks++;
      if (trace_bad !== 0) $display("FAIL random_trace: %0d cycles off, first %s", trace_bad, first_bad);
      else passes++;
      checks++;
      if (count !== exp_count) $display("FAIL random_count: got %0h, expected %0h", count, exp_count);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_forward();
      test_reverse_wrap();
      test_glitch();
      test_illegal_clr();
      test_mid_reset();
      test_strobe_modes();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
